// File: rtl/int_adder_arb_pkg.sv
// Shared types for the integer adder arbiter: FSM encoding and the requester-id width helper.
package int_alu_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_LOCK = 1'b1
  } state_e;

  function automatic int id_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/int_adder_arb_if.sv
// Requester beats in, response beats out; master = clients/downstream, slave = the arbiter.
interface int_adder_arb_if #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REQ    = 4
);
  localparam int ID_W = int_alu_pkg::id_width(NUM_REQ);

  logic [NUM_REQ-1:0]                 req_valid;
  logic [NUM_REQ-1:0]                 req_ready;
  logic [NUM_REQ-1:0]                 req_last;
  logic [NUM_REQ-1:0]                 req_cin;
  logic [NUM_REQ-1:0][DATA_WIDTH-1:0] req_a;
  logic [NUM_REQ-1:0][DATA_WIDTH-1:0] req_b;
  logic                               rsp_valid;
  logic                               rsp_ready;
  logic [ID_W-1:0]                    rsp_id;
  logic [DATA_WIDTH-1:0]              rsp_sum;
  logic                               rsp_cout;
  logic                               rsp_last;

  modport master (
    output req_valid, req_last, req_cin, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_sum, rsp_cout, rsp_last
  );

  modport slave (
    input  req_valid, req_last, req_cin, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_sum, rsp_cout, rsp_last
  );
endinterface

// File: rtl/int_adder_arb_adder.sv
// Registered adder with enable; its output registers double as the response sum/carry.
module int_adder #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  input  logic                  cin,
  output logic [DATA_WIDTH-1:0] sum,
  output logic                  cout
);
  logic [DATA_WIDTH:0] full;

  assign full = {1'b0, a} + {1'b0, b} + {{DATA_WIDTH{1'b0}}, cin};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum  <= '0;
      cout <= 1'b0;
    end else if (en) begin
      sum  <= full[DATA_WIDTH-1:0];
      cout <= full[DATA_WIDTH];
    end
  end
endmodule

// File: rtl/int_adder_arb.sv
// Round-robin sharing of one registered adder among NUM_REQ clients, with grant locking
// across multi-beat transactions and carry chained from one beat to the next.
module int_adder_arb
  import int_alu_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REQ    = 4
) (
  input logic            clk,
  input logic            rst_n,
  int_adder_arb_if.slave bus
);
  localparam int ID_W = id_width(NUM_REQ);

  state_e                state;
  logic [ID_W-1:0]       rr_ptr, owner, grant, rsp_id_q, cand;
  logic [NUM_REQ-1:0]    ready_vec;
  logic                  found, slot_free, accept, cin_sel, beat_last;
  logic                  rsp_valid_q, rsp_last_q, cout_q;
  logic [DATA_WIDTH-1:0] sum_q;

  function automatic logic [ID_W-1:0] wrap_inc(input logic [ID_W-1:0] x);
    return (x == ID_W'(NUM_REQ-1)) ? '0 : x + 1'b1;
  endfunction

  assign slot_free = !rsp_valid_q || bus.rsp_ready;

  // Only IDLE looks at valid; in LOCK the owner keeps ready even while it idles.
  always_comb begin
    grant = owner;
    found = 1'b1;
    cand  = '0;
    if (state == ST_IDLE) begin
      grant = '0;
      found = 1'b0;
      for (int k = 0; k < NUM_REQ; k++) begin
        cand = ID_W'((int'(rr_ptr) + k) % NUM_REQ);
        if (!found && bus.req_valid[cand]) begin
          found = 1'b1;
          grant = cand;
        end
      end
    end
  end

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_rdy
    assign ready_vec[i] = rst_n && slot_free && found && (grant == ID_W'(i));
  end

  assign bus.req_ready = ready_vec;
  assign accept        = |(bus.req_valid & ready_vec);
  assign beat_last     = bus.req_last[grant];
  // The adder's carry register holds the previous beat's carry-out: it is the chain carry.
  assign cin_sel       = (state == ST_LOCK) ? cout_q : bus.req_cin[grant];

  int_adder #(.DATA_WIDTH(DATA_WIDTH)) i_int_adder (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (accept),
    .a    (bus.req_a[grant]),
    .b    (bus.req_b[grant]),
    .cin  (cin_sel),
    .sum  (sum_q),
    .cout (cout_q)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      rr_ptr      <= '0;
      owner       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_last_q  <= 1'b0;
    end else begin
      if (accept) begin
        rsp_valid_q <= 1'b1;
        rsp_id_q    <= grant;
        rsp_last_q  <= beat_last;
      end else if (bus.rsp_ready) begin
        rsp_valid_q <= 1'b0;
      end
      if (accept) begin
        case (state)
          ST_IDLE: begin
            if (beat_last) begin
              rr_ptr <= wrap_inc(grant);
            end else begin
              state <= ST_LOCK;
              owner <= grant;
            end
          end
          ST_LOCK: begin
            if (beat_last) begin
              state  <= ST_IDLE;
              rr_ptr <= wrap_inc(owner);
            end
          end
        endcase
      end
    end
  end

  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_last  = rsp_last_q;
  assign bus.rsp_sum   = sum_q;
  assign bus.rsp_cout  = cout_q;
endmodule
